lsu_mem_port: RTL
=================

Name: lsu_mem_port

Overview:
- Load/store unit that consumes the effective address computed by the execute stage for load, store, flw and fsw instructions.
- Performs the access over a single-beat, word-aligned data-memory handshake and returns formatted load data for writeback.
- Sits between execute and the data-memory bus; the core stalls while req_ready is low.

Parameters:
- none. All datapaths are RV32: 32-bit address, 32-bit data, 4 byte lanes.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- req_valid  in  1  execute stage presents an access.
- req_ready  out  1  request accepted this cycle; high only in IDLE.
- opcode  in  7  0000011 = load, 0100011 = store, 0000111 = flw, 0100111 = fsw.
- funct3  in  3  access size and sign.
- addr  in  32  effective address (rs1 + imm).
- wdata  in  32  store data (src2R, or src2F for fsw).
- resp_valid  out  1  one-cycle pulse: access complete.
- rdata  out  32  formatted load result; 0 for stores and errors.
- err  out  1  misaligned or illegal access; valid with resp_valid.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts the request.
- mem_we  out  1  1 = write.
- mem_addr  out  32  {addr[31:2], 2'b00}.
- mem_wdata  out  32  lane-aligned write data.
- mem_wstrb  out  4  byte enables; 0 on reads.
- mem_resp_valid  in  1  read data valid or write acknowledge.
- mem_rdata  in  32  read word.

Behaviour:
- Reset (asynchronous, any state, including mid-access): state = IDLE; req_ready = 1; resp_valid, err, mem_req_valid, mem_we = 0; rdata, mem_addr, mem_wdata = 0; mem_wstrb = 0.
  - A bus transaction in flight at reset is abandoned; any later mem_resp_valid is ignored in IDLE.
- States: IDLE, REQ, WAIT, DONE.
- IDLE: on req_valid, latch opcode, funct3, addr[1:0], addr and wdata.
  - Legal access: go to REQ.
  - Otherwise: set err = 1, rdata = 0, go to DONE with no bus activity.
  - Illegal conditions: opcode not in the set above; load funct3 not in {000, 001, 010, 100, 101}; store funct3 not in {000, 001, 010}; flw/fsw funct3 != 010; halfword with addr[0] = 1; word with addr[1:0] != 0.
- REQ: mem_req_valid = 1, with mem_addr, mem_we, mem_wdata and mem_wstrb held stable until mem_req_ready.
  - On mem_req_ready: go to WAIT.
  - If mem_resp_valid is also high in the same cycle, capture the response and go directly to DONE.
- WAIT: mem_req_valid = 0. On mem_resp_valid: register rdata (loads only) and go to DONE.
- DONE: resp_valid = 1 for exactly one cycle, then IDLE. req_ready is low in DONE.
- Minimum latency: accept at cycle 0, REQ at cycle 1, resp_valid at cycle 3 with zero-wait memory (2 cycles when response coincides with ready). Illegal access: resp_valid at cycle 1.
- Store lanes (o = addr[1:0]):
  - sb: wstrb = 1 << o; mem_wdata = byte replicated into all 4 lanes.
  - sh: wstrb = 0011 << o; mem_wdata = halfword replicated into both halves.
  - sw/fsw: wstrb = 1111; mem_wdata = wdata.
- Load extraction (o = addr[1:0]):
  - lb: sign-extend mem_rdata[8o+7:8o]. lbu: zero-extend the same byte.
  - lh: sign-extend mem_rdata[8o+15:8o] (o ∈ {0, 2}). lhu: zero-extend the same halfword.
  - lw/flw: mem_rdata unchanged.
- rdata and err hold their values until the next access completes. req_valid is ignored outside IDLE.

Test Plan:
- Reset mid-WAIT: assert rst during WAIT -> immediately IDLE, req_ready = 1, mem_req_valid = 0; a stale mem_resp_valid the next cycle produces no resp_valid.
- lb at 0x1003, mem_rdata = 0x80FF_1234 -> mem_addr = 0x1000, wstrb = 0; rdata = 0xFFFF_FF80. lbu at the same address -> rdata = 0x0000_0080.
- lh at 0x2002, mem_rdata = 0x9ABC_0000 -> rdata = 0xFFFF_9ABC, resp_valid at cycle 3 with zero-wait memory.
- sb at 0x3001 with wdata = 0x0000_00A5 -> mem_we = 1, wstrb = 0010, mem_wdata = 0xA5A5_A5A5. sh at 0x3002 with wdata = 0x1234 -> wstrb = 1100, mem_wdata = 0x1234_1234.
- sw at 0x4002 (misaligned) -> no mem_req_valid; err = 1 and resp_valid at cycle 1. lw with funct3 = 011 -> err = 1.
- fsw at 0x5000 with wdata = 0x3F80_0000, mem_req_ready held low 3 cycles -> request fields stable throughout, wstrb = 1111. Then flw of the same address with mem_rdata = 0x3F80_0000 -> rdata = 0x3F80_0000, err = 0.

Source files
------------

// File: rtl/lsu_mem_port.sv
// rtl/lsu_mem_port.sv - RV32 load/store unit driving a single-beat word-aligned data-memory port
module lsu_mem_port (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [6:0]  opcode,
   input  logic [2:0]  funct3,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        resp_valid,
   output logic [31:0] rdata,
   output logic        err,
   output logic        mem_req_valid,
   input  logic        mem_req_ready,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_resp_valid,
   input  logic [31:0] mem_rdata
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_FLW   = 7'b0000111;
   localparam logic [6:0] OP_FSW   = 7'b0100111;

   typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
   state_t state;

   logic        is_load_q;
   logic [2:0]  f3_q;
   logic [1:0]  off_q;

   logic        legal;
   logic        ld_op;
   logic        aligned;
   logic [3:0]  wstrb_n;
   logic [31:0] wdata_n;
   logic [31:0] shifted;
   logic [31:0] ld_data;

   // Decode the incoming request: legality and lane placement of store data
   always_comb begin
      legal   = 1'b0;
      ld_op   = (opcode == OP_LOAD) || (opcode == OP_FLW);
      aligned = (addr[1:0] == 2'b00);
      case (opcode)
         OP_LOAD: begin
            case (funct3)
               3'b000, 3'b100: legal = 1'b1;
               3'b001, 3'b101: legal = ~addr[0];
               3'b010:         legal = aligned;
               default:        legal = 1'b0;
            endcase
         end
         OP_STORE: begin
            case (funct3)
               3'b000:  legal = 1'b1;
               3'b001:  legal = ~addr[0];
               3'b010:  legal = aligned;
               default: legal = 1'b0;
            endcase
         end
         OP_FLW, OP_FSW: legal = (funct3 == 3'b010) && aligned;
         default:        legal = 1'b0;
      endcase
      case (funct3[1:0])
         2'b00: begin
            wstrb_n = 4'b0001 << addr[1:0];
            wdata_n = {4{wdata[7:0]}};
         end
         2'b01: begin
            wstrb_n = 4'b0011 << addr[1:0];
            wdata_n = {2{wdata[15:0]}};
         end
         default: begin
            wstrb_n = 4'b1111;
            wdata_n = wdata;
         end
      endcase
   end

   // Extract and extend the addressed byte/halfword from the returned word
   always_comb begin
      shifted = mem_rdata >> {off_q, 3'b000};
      case (f3_q)
         3'b000:  ld_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ld_data = {24'd0, shifted[7:0]};
         3'b001:  ld_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ld_data = {16'd0, shifted[15:0]};
         default: ld_data = shifted;
      endcase
   end

   // Access sequencer with registered handshake and result outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         req_ready     <= 1'b1;
         resp_valid    <= 1'b0;
         err           <= 1'b0;
         rdata         <= 32'd0;
         mem_req_valid <= 1'b0;
         mem_we        <= 1'b0;
         mem_addr      <= 32'd0;
         mem_wdata     <= 32'd0;
         mem_wstrb     <= 4'd0;
         is_load_q     <= 1'b0;
         f3_q          <= 3'd0;
         off_q         <= 2'd0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  req_ready <= 1'b0;
                  is_load_q <= ld_op;
                  f3_q      <= funct3;
                  off_q     <= addr[1:0];
                  if (legal) begin
                     mem_req_valid <= 1'b1;
                     mem_we        <= ~ld_op;
                     mem_addr      <= {addr[31:2], 2'b00};
                     mem_wdata     <= ld_op ? 32'd0 : wdata_n;
                     mem_wstrb     <= ld_op ? 4'd0 : wstrb_n;
                     state         <= REQ;
                  end else begin
                     err        <= 1'b1;
                     rdata      <= 32'd0;
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end
               end
            end
            REQ: begin
               if (mem_req_ready) begin
                  mem_req_valid <= 1'b0;
                  if (mem_resp_valid) begin
                     rdata      <= is_load_q ? ld_data : 32'd0;
                     err        <= 1'b0;
                     resp_valid <= 1'b1;
                     state      <= DONE;
                  end else begin
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (mem_resp_valid) begin
                  rdata      <= is_load_q ? ld_data : 32'd0;
                  err        <= 1'b0;
                  resp_valid <= 1'b1;
                  state      <= DONE;
               end
            end
            default: begin
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule
